// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame geometry and parity.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIT_HI = 2'd1,
    ST_BIT_LO = 2'd2,
    ST_GAP    = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Odd parity: the 9 bits data+parity always hold an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame laid out so that bit index i is the i-th bit on the wire.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ps2_odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous active-high reset.
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: every key_action edge queues scan_code,
// and each queued byte goes out as one 11-bit frame followed by an idle gap.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_action,
  input  logic [7:0] scan_code,
  output logic       PS2_CLK,
  output logic       PS2_DAT,
  output logic       busy,
  output logic       overflow
);

  localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  ps2_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [3:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  key_action_q;
  logic                  first_q;
  logic                  ps2_clk_q, ps2_clk_d;
  logic                  ps2_dat_q, ps2_dat_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic                  transition_s;
  logic                  pop_s;
  logic                  full_s, empty_s;
  logic [7:0]            rdata_s;

  // The first cycle after reset never counts as an event, whatever key_action does.
  assign transition_s = (key_action ^ key_action_q) && !first_q;

  assign PS2_CLK  = ps2_clk_q;
  assign PS2_DAT  = ps2_dat_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .push_i  (transition_s),
    .wdata_i (scan_code),
    .pop_i   (pop_s),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Frame sequencer: next state, counters and the registered line levels.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          frame_d = ps2_frame(rdata_s);
          idx_d   = 4'd0;
          div_d   = {DIV_W{1'b0}};
          state_d = ST_BIT_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BIT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d   = {DIV_W{1'b0}};
          state_d = ST_BIT_LO;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_BIT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d = {DIV_W{1'b0}};
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_BIT_HI;
          end else begin
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_GAP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = {GAP_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Lines follow the state being entered so they are registered without extra lag.
    ps2_clk_d = (state_d != ST_BIT_LO);
    if ((state_d == ST_BIT_HI) || (state_d == ST_BIT_LO)) begin
      ps2_dat_d = frame_d[idx_d];
    end else begin
      ps2_dat_d = 1'b1;
    end

    busy_d     = (state_q != ST_IDLE) || !empty_s || transition_s;
    overflow_d = overflow_q || (transition_s && full_s && !pop_s);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= {DIV_W{1'b0}};
      gap_q        <= {GAP_W{1'b0}};
      idx_q        <= 4'd0;
      frame_q      <= {FRAME_BITS{1'b1}};
      key_action_q <= key_action;
      first_q      <= 1'b1;
      ps2_clk_q    <= 1'b1;
      ps2_dat_q    <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      key_action_q <= key_action;
      first_q      <= 1'b0;
      ps2_clk_q    <= ps2_clk_d;
      ps2_dat_q    <= ps2_dat_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule
